// File: rtl/psum_ofifo_pkg.sv
// Shared definitions for the psum output FIFO.
//  - Default geometry: PSUM_BW bits per psum, COL lanes, OFIFO_DEPTH entries per lane.
//  - lane_flags_t: per-lane status that the top level reduces into row-wide flags.
//  - ptr_bits(): pointer width for a lane of a given depth. It is one bit wider than
//    the address so that full and empty can be told apart.
package psum_ofifo_pkg;

    localparam int PSUM_BW     = 16;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 8;

    typedef struct packed {
        logic full;
        logic empty;
    } lane_flags_t;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/psum_ofifo_if.sv
// Psum bus between the MAC array bottom row, the output FIFO and the readout stage.
//  in      : packed psum row, lane i = in[psum_bw*(i+1)-1 : psum_bw*i]
//  wr      : per-lane write strobe (array valid bits)
//  rd      : pop one aligned row
//  out     : head word of every lane, same packing as in
//  o_valid : every lane non-empty
//  o_ready : no lane full
//  o_full  : at least one lane full
//  o_ovf   : sticky overflow
// master drives in/wr/rd (producer and consumer side); slave is the FIFO.
interface psum_ofifo_if
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW
);

    logic [psum_bw*col-1:0] in;
    logic [col-1:0]         wr;
    logic                   rd;
    logic [psum_bw*col-1:0] out;
    logic                   o_valid;
    logic                   o_ready;
    logic                   o_full;
    logic                   o_ovf;

    modport master (
        output in, wr, rd,
        input  out, o_valid, o_ready, o_full, o_ovf
    );

    modport slave (
        input  in, wr, rd,
        output out, o_valid, o_ready, o_full, o_ovf
    );

endinterface

// File: rtl/psum_ofifo_fifo_lane.sv
// One lane of the psum output FIFO: a first-word-fall-through ring buffer.
// Ports:
//  clk, reset : rising-edge clock, asynchronous active-low reset (clears pointers)
//  wr, in     : write strobe and data word
//  rd         : pop request, already gated by the row-wide valid at the top level
//  out        : head entry, combinational from storage and read pointer
//  full/empty : pointer-derived status
module psum_ofifo_fifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int bw    = PSUM_BW,
    parameter int depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          full,
    output logic          empty
);

    localparam int pw = ptr_bits(depth);
    localparam int aw = pw - 1;
    localparam logic [pw-1:0] ptr_one = {{aw{1'b0}}, 1'b1};

    logic [bw-1:0] mem_r [depth];
    logic [pw-1:0] wptr_r;
    logic [pw-1:0] rptr_r;
    logic          full_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          rd_en_s;

    // Status decode and write/read enables.
    always_comb begin
        full_s  = (wptr_r[aw] != rptr_r[aw]) && (wptr_r[aw-1:0] == rptr_r[aw-1:0]);
        empty_s = (wptr_r == rptr_r);
        rd_en_s = rd && !empty_s;
        // A pop in the same cycle frees the slot, so a full lane still accepts the write.
        wr_en_s = wr && (!full_s || rd_en_s);
    end

    // Storage array; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r[aw-1:0]] <= in;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + ptr_one;
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + ptr_one;
            end
        end
    end

    // Head word and flags out of the lane.
    always_comb begin
        out   = mem_r[rptr_r[aw-1:0]];
        full  = full_s;
        empty = empty_s;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Psum output FIFO downstream of the MAC row array.
// Each column has its own lane because columns finish at staggered cycles. A row is
// presented to the readout stage only when every lane holds data, and a pop moves
// all lanes together so they stay row-aligned.
// Ports:
//  clk   : rising-edge clock
//  reset : asynchronous active-low reset; discards all buffered data
//  bus   : psum_ofifo_if slave (in/wr/rd in; out/o_valid/o_ready/o_full/o_ovf out)
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    psum_ofifo_if.slave bus
);

    lane_flags_t [col-1:0]  flags_s;
    logic [psum_bw*col-1:0] head_s;
    logic                   valid_s;
    logic                   any_full_s;
    logic                   lane_rd_s;
    logic                   ovf_hit_s;
    logic                   ovf_r;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_ofifo_fifo_lane #(
            .bw    (psum_bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (bus.wr[i]),
            .rd    (lane_rd_s),
            .in    (bus.in[psum_bw*i +: psum_bw]),
            .out   (head_s[psum_bw*i +: psum_bw]),
            .full  (flags_s[i].full),
            .empty (flags_s[i].empty)
        );
    end

    // Row-wide flag reduction, pop gating and overflow detection.
    always_comb begin
        valid_s    = 1'b1;
        any_full_s = 1'b0;
        for (int i = 0; i < col; i++) begin
            valid_s    = valid_s & ~flags_s[i].empty;
            any_full_s = any_full_s | flags_s[i].full;
        end
        // A pop without a complete row is ignored, which keeps lanes aligned.
        lane_rd_s = bus.rd & valid_s;
        ovf_hit_s = 1'b0;
        for (int i = 0; i < col; i++) begin
            ovf_hit_s = ovf_hit_s | (bus.wr[i] & flags_s[i].full & ~lane_rd_s);
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | ovf_hit_s;
        end
    end

    // Output drive; out is masked to zero until a complete row is present.
    always_comb begin
        if (valid_s) begin
            bus.out = head_s;
        end else begin
            bus.out = '0;
        end
        bus.o_valid = valid_s;
        bus.o_full  = any_full_s;
        bus.o_ready = ~any_full_s;
        bus.o_ovf   = ovf_r;
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: a vector table for staggered fill and
// fill/drain, hand-written sequences for overflow, idle read and mid-op reset,
// and a random soak. A per-lane queue model acts as the scoreboard.
module tb_psum_ofifo;
    import psum_ofifo_pkg::*;

    localparam int NC = 8;
    localparam int BW = 16;
    localparam int DP = 8;
    localparam int NV = 25;

    typedef struct {
        logic [NC-1:0]    wr;
        logic             rd;
        logic [NC*BW-1:0] data;
        logic             exp_valid;
        logic             exp_full;
        logic             exp_ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    psum_ofifo_if #(.col(NC), .psum_bw(BW)) bus ();

    psum_ofifo #(.col(NC), .psum_bw(BW), .depth(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [BW-1:0] mq [NC][$];
    bit            movf;
    vec_t          vt [NV];

    task automatic chk(input string name, input logic [NC*BW-1:0] act, input logic [NC*BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NC*BW-1:0] mk_row(input logic [BW-1:0] base);
        logic [NC*BW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*BW +: BW] = base + BW'(i);
        return r;
    endfunction

    function automatic logic m_valid();
        logic v = 1'b1;
        for (int i = 0; i < NC; i++) if (mq[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic m_full();
        logic f = 1'b0;
        for (int i = 0; i < NC; i++) if (mq[i].size() == DP) f = 1'b1;
        return f;
    endfunction

    function automatic logic [NC*BW-1:0] m_heads();
        logic [NC*BW-1:0] r = '0;
        for (int i = 0; i < NC; i++) if (mq[i].size() > 0) r[i*BW +: BW] = mq[i][0];
        return r;
    endfunction

    task automatic check_model(input string name);
        chk({name, "_valid"}, NC*BW'(bus.o_valid), NC*BW'(m_valid()));
        chk({name, "_full"},  NC*BW'(bus.o_full),  NC*BW'(m_full()));
        chk({name, "_ready"}, NC*BW'(bus.o_ready), NC*BW'(!m_full()));
        chk({name, "_ovf"},   NC*BW'(bus.o_ovf),   NC*BW'(movf));
        chk({name, "_out"},   bus.out, m_valid() ? m_heads() : '0);
    endtask

    // One clock of stimulus; model updated alongside, popped row compared before the edge.
    task automatic drive(input logic [NC-1:0] wr, input logic rd, input logic [NC*BW-1:0] data);
        bit            pop;
        logic [NC-1:0] acc;
        bus.wr = wr;
        bus.rd = rd;
        bus.in = data;
        pop = rd && m_valid();
        for (int i = 0; i < NC; i++) begin
            acc[i] = wr[i] && ((mq[i].size() < DP) || pop);
            if (wr[i] && !acc[i]) movf = 1'b1;
        end
        #1;
        if (pop) chk("pop_row", bus.out, m_heads());
        if (pop) for (int i = 0; i < NC; i++) void'(mq[i].pop_front());
        for (int i = 0; i < NC; i++) if (acc[i]) mq[i].push_back(data[i*BW +: BW]);
        @(posedge clk);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
        check_model("cyc");
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        bus.wr = '1;
        bus.rd = 1'b0;
        bus.in = {4{$urandom()}};
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", NC*BW'(bus.o_valid), '0);
        chk("rst_ready", NC*BW'(bus.o_ready), NC*BW'(1'b1));
        chk("rst_ovf",   NC*BW'(bus.o_ovf),   '0);
        chk("rst_out",   bus.out,             '0);
        reset  = 1'b1;
        bus.wr = '0;
        for (int i = 0; i < NC; i++) mq[i].delete();
        movf = 1'b0;
    endtask

    initial begin
        bus.wr = '0;
        bus.rd = 1'b0;
        bus.in = '0;
        movf   = 1'b0;

        for (int i = 0; i < 8; i++)
            vt[i] = '{wr: 8'b1 << i, rd: 1'b0, data: mk_row(16'h0100),
                      exp_valid: (i == 7), exp_full: 1'b0, exp_ovf: 1'b0};
        vt[8] = '{wr: 8'h00, rd: 1'b1, data: '0, exp_valid: 1'b0, exp_full: 1'b0, exp_ovf: 1'b0};
        for (int r = 0; r < 8; r++)
            vt[9+r] = '{wr: 8'hFF, rd: 1'b0, data: mk_row(BW'(r*16)),
                        exp_valid: 1'b1, exp_full: (r == 7), exp_ovf: 1'b0};
        for (int r = 0; r < 8; r++)
            vt[17+r] = '{wr: 8'h00, rd: 1'b1, data: '0,
                         exp_valid: (r < 7), exp_full: 1'b0, exp_ovf: 1'b0};

        // Reset with writes held high, then idle after release.
        do_reset();
        drive(8'h00, 1'b0, '0);
        drive(8'h00, 1'b0, '0);
        chk("idle_valid", NC*BW'(bus.o_valid), '0);
        chk("idle_ready", NC*BW'(bus.o_ready), NC*BW'(1'b1));

        // Staggered fill, single pop, then fill to full and drain in order.
        for (int k = 0; k < NV; k++) begin
            drive(vt[k].wr, vt[k].rd, vt[k].data);
            chk("vec_valid", NC*BW'(bus.o_valid), NC*BW'(vt[k].exp_valid));
            chk("vec_full",  NC*BW'(bus.o_full),  NC*BW'(vt[k].exp_full));
            chk("vec_ready", NC*BW'(bus.o_ready), NC*BW'(!vt[k].exp_full));
            chk("vec_ovf",   NC*BW'(bus.o_ovf),   NC*BW'(vt[k].exp_ovf));
            if (k == 7) chk("stagger_out", bus.out, mk_row(16'h0100));
        end

        // Overflow: write to a full lane without a pop.
        do_reset();
        for (int r = 0; r < 8; r++) drive(8'hFF, 1'b0, mk_row(BW'(r*16)));
        drive(8'h08, 1'b0, mk_row(16'hDEA0));
        chk("ovf_set", NC*BW'(bus.o_ovf), NC*BW'(1'b1));
        chk("ovf_head3", NC*BW'(bus.out[3*BW +: BW]), NC*BW'(16'h0003));
        drive(8'h00, 1'b0, '0);
        chk("ovf_sticky", NC*BW'(bus.o_ovf), NC*BW'(1'b1));

        // Write to a full lane together with a pop is accepted.
        do_reset();
        for (int r = 0; r < 8; r++) drive(8'hFF, 1'b0, mk_row(BW'(r*16)));
        drive(8'h08, 1'b1, mk_row(16'hBEE0));
        chk("wrrd_ovf", NC*BW'(bus.o_ovf), '0);
        chk("wrrd_full", NC*BW'(bus.o_full), NC*BW'(1'b1));
        for (int r = 0; r < 7; r++) drive(8'h00, 1'b1, '0);
        chk("wrrd_drained", NC*BW'(bus.o_valid), '0);
        drive(8'hF7, 1'b0, mk_row(16'h0500));
        chk("wrrd_valid", NC*BW'(bus.o_valid), NC*BW'(1'b1));
        chk("wrrd_lane3", NC*BW'(bus.out[3*BW +: BW]), NC*BW'(16'hBEE3));
        drive(8'h00, 1'b1, '0);

        // Idle read with lane 7 empty, then lane 7 written alongside a read.
        do_reset();
        drive(8'h7F, 1'b0, mk_row(16'h0A00));
        drive(8'h00, 1'b1, '0);
        chk("idlerd_valid", NC*BW'(bus.o_valid), '0);
        drive(8'h80, 1'b1, mk_row(16'h0A00));
        chk("idlerd_valid2", NC*BW'(bus.o_valid), NC*BW'(1'b1));
        chk("idlerd_out", bus.out, mk_row(16'h0A00));

        // Mid-operation reset discards buffered rows immediately.
        do_reset();
        for (int r = 0; r < 3; r++) drive(8'hFF, 1'b0, mk_row(BW'(16'h0B00 + r*16)));
        reset = 1'b0;
        #1;
        chk("midrst_valid", NC*BW'(bus.o_valid), '0);
        chk("midrst_out", bus.out, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NC; i++) mq[i].delete();
        movf = 1'b0;
        drive(8'hFF, 1'b0, mk_row(16'h0C00));
        chk("midrst_new", bus.out, mk_row(16'h0C00));
        drive(8'h00, 1'b1, '0);
        chk("midrst_single", NC*BW'(bus.o_valid), '0);

        // Random soak against the queue model.
        do_reset();
        for (int n = 0; n < 400; n++)
            drive(8'($urandom() | $urandom()), 1'($urandom_range(0, 2) == 0),
                  {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int n = 0; n < 10; n++) drive(8'h00, 1'b1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
